prewish5k_mask_loader: RTL and testbench
========================================

// Module: prewish5k_mask_loader
// PURPOSE
//  Multi-channel successor to the single-button DIP mask loader in the top-level controller.
//  Watches NCHAN debounced button levels. A rising edge on a button latches the DIP word for that channel.
//  Events are queued in a FIFO and presented downstream (mentor/blinky) over a STB/ACK handshake tagged with the channel index.
//  Sits between the debouncer outputs and the mentor STB_I/DAT_I.
// PARAMETERS
//  NCHAN          4   number of button channels (1..8)
//  DW             8   DIP/mask data width
//  FIFO_DEPTH     4   event queue depth; power of 2, >=2
//  ALIVE_BITS     23  alive-counter width; o_alive = counter MSB
//  REPEAT_BITS    22  auto-repeat period = 2**REPEAT_BITS clocks (used only with MASK_LOADER_REPEAT_EN)
// PORTS
//  CLK_I       in   1               system clock
//  RST_I       in   1               asynchronous reset, active-low
//  i_buttons   in   NCHAN           debounced button levels, active-high
//  i_dip       in   DW              DIP word, active-high (already inverted by the caller)
//  STB_O       out  1               event valid; held until ACK_I
//  DAT_O       out  DW              mask captured for the event
//  CHN_O       out  max(1,$clog2(NCHAN))  channel index of the event
//  ACK_I       in   1               downstream accept, sampled while STB_O=1
//  o_overflow  out  1               sticky: an event was lost; cleared only by reset
//  o_alive     out  1               free-running alive indicator
// BEHAVIOUR
//  Reset (RST_I=0, async)
//   - STB_O=0, DAT_O=0, CHN_O=0, o_overflow=0, o_alive=0.
//   - FIFO empty; pending bitmap cleared; shadows cleared.
//   - prev_btn set to all 1s: a button held through reset gives no event until it is released and pressed again.
//   - Reset mid-handshake drops the in-flight event silently.
//  Edge capture (cycle k: i_buttons[c]=1 and prev_btn[c]=0)
//   - shadow[c] <= i_dip; pending[c] <= 1.
//   - If pending[c] was already 1, the shadow is overwritten with the newer DIP word and o_overflow <= 1.
//  Arbiter
//   - Each cycle, the lowest-index pending channel is pushed {c, shadow[c]} into the FIFO and its pending bit is cleared.
//   - At most one push per cycle.
//   - FIFO full: no push; pending bits stay set (backpressure, no loss).
//   - A new edge on the same channel in the push cycle sets pending again (new event wins over clear).
//  Output FSM (IDLE, PRESENT, GAP)
//   - IDLE: FIFO not empty -> pop into DAT_O/CHN_O, STB_O<=1, go to PRESENT.
//   - PRESENT: DAT_O/CHN_O stable. ACK_I=1 -> STB_O<=0, go to GAP. Otherwise stay.
//   - GAP: one idle cycle, go to IDLE. STB_O is never high two events back-to-back.
//  Latency: edge sampled at k -> FIFO push at k+1 -> STB_O=1 after edge k+2 (queue empty, FSM idle).
//  Throughput: one event per 3 clocks when ACK_I is tied high.
//  FIFO: count width $clog2(FIFO_DEPTH)+1; pointers wrap modulo depth.
//   - Push and pop in the same cycle are allowed at any fill level, including full.
// CONFIGURATION
//  `MASK_LOADER_REPEAT_EN defined:
//   - Per-channel hold timer restarts on each capture.
//   - While the button stays high, every 2**REPEAT_BITS clocks the channel re-captures i_dip and sets pending (auto-repeat).
//   - Release stops the timer.
//  Not defined: edge-only behaviour; no hold timers synthesised; REPEAT_BITS ignored.
// STRUCTURE
//  Package prewish5k_pkg:
//   - output FSM state localparams (IDLE=2'b00, PRESENT=2'b01, GAP=2'b10)
//   - CHW/entry-width function: entry = {CHW, DW} bits.
//  Sub-module prewish5k_sync_fifo:
//   - parametrised width/depth; push/pop/full/empty/count; async active-low reset.
//  Edge detect, arbiter, output FSM and repeat timers stay in this module.
// TESTING
//  1 ch2 rises, i_dip=8'hA5, ACK_I=0 for 10 clks -> STB_O=1 from edge k+2, DAT_O=A5, CHN_O=2 held stable; ACK_I -> STB_O=0 next clk, no second event.
//  2 ch0 and ch3 rise same cycle, i_dip=8'h3C, ACK_I=1 -> two events: CHN_O=0 then CHN_O=3, both DAT_O=3C, 3-clk spacing.
//  3 ACK_I=0; 6 presses spread over ch0..ch3 -> 4 queued + 1 presenting + remainder pending. ACK each -> all delivered in arrival/priority order; o_overflow=0.
//  4 ch1 pressed twice (DIP 11 then 22) while FIFO full -> one ch1 event with DAT_O=22; o_overflow=1 until reset.
//  5 ch1 held high across RST_I pulse, kept high 100 clks -> no STB_O; release+press -> one event.
//  6 REPEAT_BITS=4, macro defined, ch0 held 70 clks, ACK_I=1 -> 1 initial + 4 repeat events. Macro undefined -> exactly 1.

Source files
------------

// File: rtl/prewish5k_pkg.sv
// rtl/prewish5k_pkg.sv - shared types and width helpers for the multi-channel mask loader
package prewish5k_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESENT = 2'b01,
        ST_GAP     = 2'b10
    } out_state_t;

    function automatic int chw(input int nchan);
        return (nchan > 1) ? $clog2(nchan) : 1;
    endfunction

    // A queued event is {channel, mask}.
    function automatic int entry_w(input int nchan, input int dw);
        return chw(nchan) + dw;
    endfunction

endpackage

// File: rtl/prewish5k_sync_fifo.sv
// rtl/prewish5k_sync_fifo.sv - synchronous FIFO, power-of-2 depth, async active-low reset
module prewish5k_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prewish5k_mask_loader.sv
// rtl/prewish5k_mask_loader.sv - per-button DIP capture, event queue and STB/ACK presenter
// Optional auto-repeat on held buttons when MASK_LOADER_REPEAT_EN is defined.
module prewish5k_mask_loader
    import prewish5k_pkg::*;
#(
    parameter int NCHAN       = 4,
    parameter int DW          = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int ALIVE_BITS  = 23,
    parameter int REPEAT_BITS = 22
)(
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic [NCHAN-1:0]         i_buttons,
    input  logic [DW-1:0]            i_dip,
    output logic                     STB_O,
    output logic [DW-1:0]            DAT_O,
    output logic [chw(NCHAN)-1:0]    CHN_O,
    input  logic                     ACK_I,
    output logic                     o_overflow,
    output logic                     o_alive
);

    localparam int CHW = chw(NCHAN);
    localparam int EW  = entry_w(NCHAN, DW);

    logic [NCHAN-1:0]          prev_btn;
    logic [NCHAN-1:0]          pending;
    logic [NCHAN-1:0]          rise;
    logic [NCHAN-1:0]          rep_req;
    logic [NCHAN-1:0]          cap;
    logic [NCHAN-1:0]          clr;
    logic [DW-1:0]             shadow [NCHAN];

    logic                      sel_valid;
    logic [CHW-1:0]            sel_idx;
    logic [DW-1:0]             sel_dat;
    logic [NCHAN-1:0]          sel_onehot;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [EW-1:0]             fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

    out_state_t                state_q;
    out_state_t                state_d;
    logic [ALIVE_BITS-1:0]     alive_cnt;

    assign rise = i_buttons & ~prev_btn;
    assign cap  = rise | rep_req;

`ifdef MASK_LOADER_REPEAT_EN
    logic [REPEAT_BITS-1:0]    hold_cnt [NCHAN];
    logic [NCHAN-1:0]          held;

    // Timers arm only on a real capture, so a button held through reset never repeats.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            held <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                hold_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (!i_buttons[c]) begin
                    held[c]     <= 1'b0;
                    hold_cnt[c] <= '0;
                end else if (cap[c]) begin
                    held[c]     <= 1'b1;
                    hold_cnt[c] <= '0;
                end else if (held[c]) begin
                    hold_cnt[c] <= hold_cnt[c] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rep_req = '0;
        for (int c = 0; c < NCHAN; c++) begin
            rep_req[c] = held[c] && i_buttons[c] && (hold_cnt[c] == '1);
        end
    end
`else
    logic unused_repeat_bits;
    assign unused_repeat_bits = (REPEAT_BITS > 0);
    assign rep_req = '0;
`endif

    // Fixed priority: lowest-index pending channel wins.
    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = '0;
        sel_dat    = '0;
        sel_onehot = '0;
        for (int c = NCHAN - 1; c >= 0; c--) begin
            if (pending[c]) begin
                sel_valid     = 1'b1;
                sel_idx       = CHW'(c);
                sel_dat       = shadow[c];
                sel_onehot    = '0;
                sel_onehot[c] = 1'b1;
            end
        end
    end

    assign fifo_push = sel_valid && !fifo_full;
    assign clr       = fifo_push ? sel_onehot : '0;

    // A fresh capture re-sets pending even when the old event is being pushed.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            prev_btn   <= '1;
            pending    <= '0;
            o_overflow <= 1'b0;
            for (int c = 0; c < NCHAN; c++) begin
                shadow[c] <= '0;
            end
        end else begin
            prev_btn <= i_buttons;
            pending  <= (pending & ~clr) | cap;
            if (|(cap & pending & ~clr)) begin
                o_overflow <= 1'b1;
            end
            for (int c = 0; c < NCHAN; c++) begin
                if (cap[c]) begin
                    shadow[c] <= i_dip;
                end
            end
        end
    end

    prewish5k_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK_I),
        .rst_n (RST_I),
        .push  (fifo_push),
        .wdata ({sel_idx, sel_dat}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (ACK_I) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            STB_O <= 1'b0;
            DAT_O <= '0;
            CHN_O <= '0;
        end else if (fifo_pop) begin
            STB_O          <= 1'b1;
            {CHN_O, DAT_O} <= fifo_rdata;
        end else if (state_q == ST_PRESENT && ACK_I) begin
            STB_O <= 1'b0;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            alive_cnt <= '0;
        end else begin
            alive_cnt <= alive_cnt + 1'b1;
        end
    end

    assign o_alive = alive_cnt[ALIVE_BITS-1];

endmodule

// File: tb/tb_prewish5k_mask_loader.sv
// tb/tb_prewish5k_mask_loader.sv - directed scoreboard bench for prewish5k_mask_loader
module tb_prewish5k_mask_loader;

    logic       CLK_I = 1'b0;
    logic       RST_I;
    logic [3:0] i_buttons;
    logic [7:0] i_dip;
    logic       STB_O;
    logic [7:0] DAT_O;
    logic [1:0] CHN_O;
    logic       ACK_I;
    logic       o_overflow;
    logic       o_alive;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int seen     = 0;
    int n_exp;

    typedef struct packed {
        logic [1:0] chn;
        logic [7:0] dat;
    } ev_t;

    ev_t sb[$];
    int  stamps[$];

    always #5 CLK_I = ~CLK_I;

    prewish5k_mask_loader #(
        .NCHAN       (4),
        .DW          (8),
        .FIFO_DEPTH  (4),
        .ALIVE_BITS  (4),
        .REPEAT_BITS (4)
    ) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .i_buttons  (i_buttons),
        .i_dip      (i_dip),
        .STB_O      (STB_O),
        .DAT_O      (DAT_O),
        .CHN_O      (CHN_O),
        .ACK_I      (ACK_I),
        .o_overflow (o_overflow),
        .o_alive    (o_alive)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK_I);
        cyc++;
    endtask

    task automatic expect_ev(input logic [1:0] c, input logic [7:0] d);
        ev_t e;
        e.chn = c;
        e.dat = d;
        sb.push_back(e);
    endtask

    task automatic check_ev(input string tag);
        ev_t e;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_event"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_chn"}, 32'(CHN_O), 32'(e.chn));
            chk({tag, "_dat"}, 32'(DAT_O), 32'(e.dat));
        end
    endtask

    task automatic deliver(input string tag, input int budget);
        int n = 0;
        while (!STB_O && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_stb"}, 32'(STB_O), 32'd1);
        if (STB_O) begin
            check_ev(tag);
            ACK_I = 1'b1;
            tick();
            chk({tag, "_drop"}, 32'(STB_O), 32'd0);
            ACK_I = 1'b0;
        end
    endtask

    task automatic collect(input int cycles);
        repeat (cycles) begin
            tick();
            if (STB_O) begin
                seen++;
                stamps.push_back(cyc);
                check_ev("collect");
            end
        end
    endtask

    task automatic quiet(input string tag, input int cycles);
        int hits = 0;
        repeat (cycles) begin
            tick();
            if (STB_O) hits++;
        end
        chk(tag, 32'(hits), 32'd0);
    endtask

    task automatic pulse(input int c, input logic [7:0] d, input bit queued);
        i_dip        = d;
        i_buttons[c] = 1'b1;
        tick();
        i_buttons[c] = 1'b0;
        tick();
        if (queued) expect_ev(2'(c), d);
    endtask

    initial begin
        bit stable;
        RST_I     = 1'b0;
        i_buttons = '0;
        i_dip     = '0;
        ACK_I     = 1'b0;
        tick();
        tick();
        chk("rst_stb", 32'(STB_O), 32'd0);
        chk("rst_dat", 32'(DAT_O), 32'd0);
        chk("rst_chn", 32'(CHN_O), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_alive", 32'(o_alive), 32'd0);
        RST_I = 1'b1;
        repeat (7) tick();
        chk("alive_7", 32'(o_alive), 32'd0);
        tick();
        chk("alive_8", 32'(o_alive), 32'd1);

        // 1: single event, held without ACK
        i_dip        = 8'hA5;
        i_buttons[2] = 1'b1;
        expect_ev(2'd2, 8'hA5);
        tick();
        chk("t1_lat_k", 32'(STB_O), 32'd0);
        tick();
        chk("t1_lat_k1", 32'(STB_O), 32'd0);
        tick();
        chk("t1_lat_k2", 32'(STB_O), 32'd1);
        check_ev("t1");
        i_dip  = 8'h00;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (!(STB_O === 1'b1 && CHN_O === 2'd2 && DAT_O === 8'hA5)) stable = 1'b0;
        end
        chk("t1_hold", 32'(stable), 32'd1);
        ACK_I = 1'b1;
        tick();
        chk("t1_ack", 32'(STB_O), 32'd0);
        ACK_I        = 1'b0;
        i_buttons[2] = 1'b0;
        quiet("t1_no_second", 12);

        // 2: simultaneous ch0/ch3, ACK tied high
        ACK_I     = 1'b1;
        i_dip     = 8'h3C;
        i_buttons = 4'b1001;
        expect_ev(2'd0, 8'h3C);
        expect_ev(2'd3, 8'h3C);
        tick();
        i_buttons = 4'b0000;
        stamps.delete();
        collect(12);
        chk("t2_count", 32'(stamps.size()), 32'd2);
        if (stamps.size() == 2) chk("t2_spacing", 32'(stamps[1] - stamps[0]), 32'd3);
        ACK_I = 1'b0;

        // 3: fill queue with ACK held low, then drain in order
        pulse(0, 8'h01, 1'b1);
        pulse(1, 8'h02, 1'b1);
        pulse(2, 8'h03, 1'b1);
        pulse(3, 8'h04, 1'b1);
        pulse(0, 8'h05, 1'b1);
        pulse(1, 8'h06, 1'b1);
        chk("t3_ovf_pre", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 6; i++) deliver("t3", 20);
        chk("t3_ovf_post", 32'(o_overflow), 32'd0);

        // 4: double press on ch1 while FIFO full
        pulse(0, 8'h10, 1'b1);
        pulse(2, 8'h20, 1'b1);
        pulse(3, 8'h30, 1'b1);
        pulse(0, 8'h40, 1'b1);
        pulse(2, 8'h50, 1'b1);
        pulse(1, 8'h11, 1'b0);
        pulse(1, 8'h22, 1'b1);
        chk("t4_ovf_set", 32'(o_overflow), 32'd1);
        for (int i = 0; i < 6; i++) deliver("t4", 20);
        chk("t4_ovf_sticky", 32'(o_overflow), 32'd1);
        quiet("t4_quiet", 8);

        // 5: ch1 held across reset
        i_buttons[1] = 1'b1;
        RST_I        = 1'b0;
        tick();
        chk("t5_rst_stb", 32'(STB_O), 32'd0);
        chk("t5_rst_dat", 32'(DAT_O), 32'd0);
        chk("t5_rst_ovf", 32'(o_overflow), 32'd0);
        tick();
        RST_I = 1'b1;
        quiet("t5_held", 100);
        i_buttons[1] = 1'b0;
        tick();
        pulse(1, 8'h5A, 1'b1);
        deliver("t5", 10);
        quiet("t5_after", 8);

        // 6: long hold with ACK high
`ifdef MASK_LOADER_REPEAT_EN
        n_exp = 5;
`else
        n_exp = 1;
`endif
        ACK_I = 1'b1;
        i_dip = 8'h77;
        for (int i = 0; i < n_exp; i++) expect_ev(2'd0, 8'h77);
        seen         = 0;
        i_buttons[0] = 1'b1;
        collect(70);
        i_buttons[0] = 1'b0;
        collect(15);
        chk("t6_events", 32'(seen), 32'(n_exp));
        ACK_I = 1'b0;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
